// File: rtl/kb_cursor_ctrl_if.sv
// Keyboard-byte input and engine move handshake between kb_cursor_ctrl and its neighbours.
// The slave side is the cursor controller; the master side is the receiver and engine.
interface kb_cursor_ctrl_if;
    logic       scan_ready;
    logic [7:0] scan_code;
    logic       move_valid;
    logic [5:0] move_from;
    logic [5:0] move_to;
    logic       move_ready;

    modport master (
        output scan_ready, scan_code, move_ready,
        input  move_valid, move_from, move_to
    );

    modport slave (
        input  scan_ready, scan_code, move_ready,
        output move_valid, move_from, move_to
    );
endinterface

// File: rtl/kb_cursor_ctrl.sv
// PS/2 scan-byte decoder driving an 8x8 board cursor and the two-step from/to move selection.
// Completed moves are offered to the engine over a valid/ready handshake.
module kb_cursor_ctrl #(
    parameter bit         WRAP        = 1'b0,
    parameter logic [2:0] INIT_ROW    = 3'd0,
    parameter logic [2:0] INIT_COL    = 3'd4,
    parameter int         PFX_TIMEOUT = 500000
) (
    input  logic            clk50,
    input  logic            reset_kb,
    kb_cursor_ctrl_if.slave kb,
    output logic [2:0]      cursor_row,
    output logic [2:0]      cursor_col,
    output logic [1:0]      phase,
    output logic [5:0]      from_sq,
    output logic            key_evt
);
    localparam int TW = $clog2(PFX_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(PFX_TIMEOUT - 1);

    typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_t;
    typedef enum logic [1:0] {SEL_FROM = 2'd0, SEL_TO = 2'd1, WAIT_ACK = 2'd2} sel_t;

    dec_t          dec_st, dec_nxt;
    sel_t          sel_st, sel_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic          scan_rdy_p1;
    logic [2:0]    row_nxt, col_nxt;
    logic [5:0]    from_nxt, mf_nxt, mt_nxt, move_from_r, move_to_r;
    logic          mv_nxt, move_valid_r, evt_nxt;

    // Edge-of-board stepping: saturate or wrap depending on WRAP.
    function automatic logic [2:0] step_pos(input logic [2:0] v, input logic inc);
        if (inc) return (v == 3'd7) ? (WRAP ? 3'd0 : 3'd7) : v + 3'd1;
        else     return (v == 3'd0) ? (WRAP ? 3'd7 : 3'd0) : v - 3'd1;
    endfunction

    logic accept, is_pfx, mk_norm, mk_ext;
    logic k_up, k_dn, k_lf, k_rt, k_ent, k_esc, k_arrow;

    assign accept  = kb.scan_ready && !scan_rdy_p1;
    assign is_pfx  = (kb.scan_code == 8'hE0) || (kb.scan_code == 8'hF0);
    assign mk_norm = accept && !is_pfx && (dec_st == D_IDLE);
    assign mk_ext  = accept && !is_pfx && (dec_st == D_EXT);
    assign k_up    = mk_ext  && (kb.scan_code == 8'h75);
    assign k_dn    = mk_ext  && (kb.scan_code == 8'h72);
    assign k_lf    = mk_ext  && (kb.scan_code == 8'h6B);
    assign k_rt    = mk_ext  && (kb.scan_code == 8'h74);
    assign k_ent   = mk_norm && (kb.scan_code == 8'h5A);
    assign k_esc   = mk_norm && (kb.scan_code == 8'h76);
    assign k_arrow = k_up || k_dn || k_lf || k_rt;

    always_ff @(posedge clk50) begin
        if (!reset_kb) begin
            scan_rdy_p1  <= 1'b0;
            dec_st       <= D_IDLE;
            tmr          <= '0;
            sel_st       <= SEL_FROM;
            cursor_row   <= INIT_ROW;
            cursor_col   <= INIT_COL;
            from_sq      <= '0;
            move_valid_r <= 1'b0;
            move_from_r  <= '0;
            move_to_r    <= '0;
            key_evt      <= 1'b0;
        end else begin
            scan_rdy_p1  <= kb.scan_ready;
            dec_st       <= dec_nxt;
            tmr          <= tmr_nxt;
            sel_st       <= sel_nxt;
            cursor_row   <= row_nxt;
            cursor_col   <= col_nxt;
            from_sq      <= from_nxt;
            move_valid_r <= mv_nxt;
            move_from_r  <= mf_nxt;
            move_to_r    <= mt_nxt;
            key_evt      <= evt_nxt;
        end
    end

    // Prefix decoder; a stale E0/F0 is dropped after PFX_TIMEOUT idle cycles.
    always_comb begin
        dec_nxt = dec_st;
        tmr_nxt = tmr;
        if (accept) begin
            tmr_nxt = '0;
            if (kb.scan_code == 8'hE0)
                dec_nxt = D_EXT;
            else if (kb.scan_code == 8'hF0)
                dec_nxt = (dec_st == D_EXT || dec_st == D_EXT_BRK) ? D_EXT_BRK : D_BRK;
            else
                dec_nxt = D_IDLE;
        end else if (dec_st != D_IDLE) begin
            if (tmr == TMAX) begin
                dec_nxt = D_IDLE;
                tmr_nxt = '0;
            end else begin
                tmr_nxt = tmr + 1'b1;
            end
        end
    end

    always_comb begin
        sel_nxt  = sel_st;
        row_nxt  = cursor_row;
        col_nxt  = cursor_col;
        from_nxt = from_sq;
        mv_nxt   = move_valid_r;
        mf_nxt   = move_from_r;
        mt_nxt   = move_to_r;
        evt_nxt  = 1'b0;
        case (sel_st)
            SEL_FROM, SEL_TO: begin
                if (k_arrow) begin
                    evt_nxt = 1'b1;
                    if (k_up) row_nxt = step_pos(cursor_row, 1'b1);
                    if (k_dn) row_nxt = step_pos(cursor_row, 1'b0);
                    if (k_rt) col_nxt = step_pos(cursor_col, 1'b1);
                    if (k_lf) col_nxt = step_pos(cursor_col, 1'b0);
                end
                if (k_esc) begin
                    evt_nxt = 1'b1;
                    sel_nxt = SEL_FROM;
                end
                if (k_ent) begin
                    evt_nxt = 1'b1;
                    if (sel_st == SEL_FROM) begin
                        from_nxt = {cursor_row, cursor_col};
                        sel_nxt  = SEL_TO;
                    end else if ({cursor_row, cursor_col} == from_sq) begin
                        sel_nxt  = SEL_FROM;
                    end else begin
                        mf_nxt  = from_sq;
                        mt_nxt  = {cursor_row, cursor_col};
                        mv_nxt  = 1'b1;
                        sel_nxt = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (move_valid_r && kb.move_ready) begin
                    mv_nxt  = 1'b0;
                    sel_nxt = SEL_FROM;
                end
            end
            default: sel_nxt = SEL_FROM;
        endcase
    end

    assign phase         = sel_st;
    assign kb.move_valid = move_valid_r;
    assign kb.move_from  = move_from_r;
    assign kb.move_to    = move_to_r;
endmodule

// File: tb/tb_kb_cursor_ctrl.sv
// Directed bench for kb_cursor_ctrl: a saturating and a wrapping instance share one byte stream.
module tb_kb_cursor_ctrl;
    logic       clk50 = 1'b0;
    logic       reset_kb;
    logic [2:0] row0, col0, row1, col1;
    logic [1:0] phase0, phase1;
    logic [5:0] from0, from1;
    logic       evt0, evt1;
    int         checks = 0;
    int         errors = 0;
    int         evt_cnt = 0;
    bit         mv_seen = 1'b0;

    kb_cursor_ctrl_if bus0();
    kb_cursor_ctrl_if bus1();

    assign bus1.scan_ready = bus0.scan_ready;
    assign bus1.scan_code  = bus0.scan_code;
    assign bus1.move_ready = bus0.move_ready;

    kb_cursor_ctrl #(.WRAP(1'b0), .PFX_TIMEOUT(64)) u_sat (
        .clk50(clk50), .reset_kb(reset_kb), .kb(bus0.slave),
        .cursor_row(row0), .cursor_col(col0), .phase(phase0),
        .from_sq(from0), .key_evt(evt0)
    );

    kb_cursor_ctrl #(.WRAP(1'b1), .PFX_TIMEOUT(64)) u_wrap (
        .clk50(clk50), .reset_kb(reset_kb), .kb(bus1.slave),
        .cursor_row(row1), .cursor_col(col1), .phase(phase1),
        .from_sq(from1), .key_evt(evt1)
    );

    always #10 clk50 = ~clk50;

    always @(negedge clk50) begin
        if (evt0) evt_cnt = evt_cnt + 1;
        if (bus0.move_valid) mv_seen = 1'b1;
    end

    task automatic do_reset();
        reset_kb = 1'b0;
        bus0.scan_ready = 1'b0;
        bus0.scan_code  = 8'h00;
        bus0.move_ready = 1'b0;
        repeat (2) @(posedge clk50);
        #1;
        reset_kb = 1'b1;
        mv_seen  = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bus0.scan_code  = b;
        bus0.scan_ready = 1'b1;
        @(posedge clk50);
        #1;
        bus0.scan_ready = 1'b0;
        @(posedge clk50);
        #1;
    endtask

    task automatic up();
        send(8'hE0);
        send(8'h75);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (row0 !== 3'd0) begin errors++; $display("FAIL reset_row got %0d want 0", row0); end
        checks++; if (col0 !== 3'd4) begin errors++; $display("FAIL reset_col got %0d want 4", col0); end
        checks++; if (phase0 !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase0); end
        checks++; if (bus0.move_valid !== 1'b0 || evt0 !== 1'b0) begin
            errors++; $display("FAIL reset_flags got mv=%b evt=%b want 0 0", bus0.move_valid, evt0); end
        checks++; if (from0 !== 6'd0 || bus0.move_from !== 6'd0 || bus0.move_to !== 6'd0) begin
            errors++; $display("FAIL reset_squares got %o %o %o want 0 0 0", from0, bus0.move_from, bus0.move_to); end
    endtask

    task automatic test_arrow();
        int c0;
        do_reset();
        c0 = evt_cnt;
        up();
        checks++; if (row0 !== 3'd1) begin errors++; $display("FAIL up_row got %0d want 1", row0); end
        checks++; if (col0 !== 3'd4) begin errors++; $display("FAIL up_col got %0d want 4", col0); end
        checks++; if (evt_cnt - c0 !== 1) begin errors++; $display("FAIL up_evt got %0d want 1", evt_cnt - c0); end
        send(8'hE0); send(8'h6B);
        checks++; if (col0 !== 3'd3) begin errors++; $display("FAIL left_col got %0d want 3", col0); end
        send(8'hE0); send(8'h74); send(8'hE0); send(8'h74);
        checks++; if (col0 !== 3'd5) begin errors++; $display("FAIL right_col got %0d want 5", col0); end
        send(8'h75);
        checks++; if (row0 !== 3'd1) begin errors++; $display("FAIL keypad_row got %0d want 1", row0); end
    endtask

    task automatic test_break();
        int c0;
        do_reset();
        c0 = evt_cnt;
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hF0); send(8'h5A);
        checks++; if (row0 !== 3'd0 || col0 !== 3'd4) begin
            errors++; $display("FAIL break_cursor got %0d,%0d want 0,4", row0, col0); end
        checks++; if (phase0 !== 2'd0) begin errors++; $display("FAIL break_phase got %0d want 0", phase0); end
        checks++; if (evt_cnt - c0 !== 0) begin errors++; $display("FAIL break_evt got %0d want 0", evt_cnt - c0); end
    endtask

    task automatic test_edges();
        int c0;
        do_reset();
        send(8'hE0); send(8'h72);
        checks++; if (row0 !== 3'd0) begin errors++; $display("FAIL sat_low got %0d want 0", row0); end
        checks++; if (row1 !== 3'd7) begin errors++; $display("FAIL wrap_low got %0d want 7", row1); end
        do_reset();
        repeat (7) up();
        checks++; if (row0 !== 3'd7 || row1 !== 3'd7) begin
            errors++; $display("FAIL at_top got %0d,%0d want 7,7", row0, row1); end
        c0 = evt_cnt;
        up();
        checks++; if (row1 !== 3'd0) begin errors++; $display("FAIL wrap_high got %0d want 0", row1); end
        up(); up();
        checks++; if (row0 !== 3'd7) begin errors++; $display("FAIL sat_high got %0d want 7", row0); end
        checks++; if (evt_cnt - c0 !== 3) begin errors++; $display("FAIL sat_evt got %0d want 3", evt_cnt - c0); end
    endtask

    task automatic test_move();
        int c0;
        do_reset();
        send(8'h5A);
        checks++; if (phase0 !== 2'd1 || from0 !== 6'o04) begin
            errors++; $display("FAIL sel_from got phase=%0d from=%o want 1 04", phase0, from0); end
        up(); up();
        send(8'h5A);
        checks++; if (bus0.move_valid !== 1'b1 || phase0 !== 2'd2) begin
            errors++; $display("FAIL offer got mv=%b phase=%0d want 1 2", bus0.move_valid, phase0); end
        checks++; if (bus0.move_from !== 6'o04 || bus0.move_to !== 6'o24) begin
            errors++; $display("FAIL offer_sq got %o->%o want 04->24", bus0.move_from, bus0.move_to); end
        c0 = evt_cnt;
        for (int i = 0; i < 10; i++) begin
            send((i % 2 == 0) ? 8'hE0 : 8'h75);
            checks++;
            if (bus0.move_valid !== 1'b1 || bus0.move_from !== 6'o04 || bus0.move_to !== 6'o24 || row0 !== 3'd2) begin
                errors++; $display("FAIL hold got mv=%b %o->%o row=%0d want 1 04->24 row 2",
                                   bus0.move_valid, bus0.move_from, bus0.move_to, row0); end
        end
        checks++; if (evt_cnt - c0 !== 0) begin errors++; $display("FAIL hold_evt got %0d want 0", evt_cnt - c0); end
        bus0.move_ready = 1'b1;
        @(posedge clk50); #1;
        bus0.move_ready = 1'b0;
        checks++; if (bus0.move_valid !== 1'b0 || phase0 !== 2'd0) begin
            errors++; $display("FAIL ack got mv=%b phase=%0d want 0 0", bus0.move_valid, phase0); end
    endtask

    task automatic test_deselect();
        do_reset();
        send(8'h5A); send(8'h5A);
        checks++; if (phase0 !== 2'd0 || mv_seen !== 1'b0) begin
            errors++; $display("FAIL deselect got phase=%0d mv_seen=%b want 0 0", phase0, mv_seen); end
        send(8'h5A);
        checks++; if (phase0 !== 2'd1) begin errors++; $display("FAIL reselect got %0d want 1", phase0); end
        send(8'h76);
        checks++; if (phase0 !== 2'd0) begin errors++; $display("FAIL esc got %0d want 0", phase0); end
    endtask

    task automatic test_timeout();
        int c0;
        do_reset();
        c0 = evt_cnt;
        send(8'hE0);
        repeat (80) @(posedge clk50);
        #1;
        send(8'h75);
        checks++; if (row0 !== 3'd0) begin errors++; $display("FAIL timeout_row got %0d want 0", row0); end
        checks++; if (evt_cnt - c0 !== 0) begin errors++; $display("FAIL timeout_evt got %0d want 0", evt_cnt - c0); end
    endtask

    task automatic test_level_ready();
        int c0;
        do_reset();
        c0 = evt_cnt;
        bus0.scan_code  = 8'h5A;
        bus0.scan_ready = 1'b1;
        repeat (10) @(posedge clk50);
        #1;
        bus0.scan_ready = 1'b0;
        @(posedge clk50); #1;
        checks++; if (phase0 !== 2'd1) begin errors++; $display("FAIL level_phase got %0d want 1", phase0); end
        checks++; if (evt_cnt - c0 !== 1) begin errors++; $display("FAIL level_evt got %0d want 1", evt_cnt - c0); end
    endtask

    task automatic test_reset_mid_handshake();
        do_reset();
        send(8'h5A); up(); send(8'h5A);
        checks++; if (bus0.move_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_mv got %b want 1", bus0.move_valid); end
        reset_kb = 1'b0;
        @(posedge clk50); #1;
        reset_kb = 1'b1;
        @(posedge clk50); #1;
        checks++; if (bus0.move_valid !== 1'b0 || phase0 !== 2'd0) begin
            errors++; $display("FAIL rst_mid got mv=%b phase=%0d want 0 0", bus0.move_valid, phase0); end
    endtask

    initial begin
        test_reset();
        test_arrow();
        test_break();
        test_edges();
        test_move();
        test_deselect();
        test_timeout();
        test_level_ready();
        test_reset_mid_handshake();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
